// File: rtl/me_pkg.sv
// Shared types and widths for the integer-pel motion-estimation search sequencer.
package me_pkg;

  localparam int ME_ADDR_W = 6;
  localparam int ME_SAD_W  = 16;

  localparam logic [ME_SAD_W-1:0] ME_SAD_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    DRAIN,
    DONE
  } me_state_t;

  typedef struct packed {
    logic                 valid;
    logic [ME_ADDR_W-1:0] x;
    logic [ME_ADDR_W-1:0] y;
  } me_cand_t;

endpackage

// File: rtl/me_cand_delay.sv
// Fixed-depth shift register that carries each candidate's coordinates alongside
// the SAD pipeline so they reach the comparator together with the matching SAD.
module me_cand_delay
  import me_pkg::*;
#(
  parameter int SAD_LAT = 3
) (
  input  logic                 clk,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [ME_ADDR_W-1:0] in_x,
  input  logic [ME_ADDR_W-1:0] in_y,
  output logic                 out_valid,
  output logic [ME_ADDR_W-1:0] out_x,
  output logic [ME_ADDR_W-1:0] out_y
);

  me_cand_t pipe_d [SAD_LAT];
  me_cand_t pipe_q [SAD_LAT];

  // Next stage contents: new candidate enters stage 0, every other stage takes its predecessor.
  always_comb begin
    pipe_d[0].valid = in_valid;
    pipe_d[0].x     = in_x;
    pipe_d[0].y     = in_y;
    for (int i = 1; i < SAD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Shift every cycle unconditionally; flush empties the line so no stale candidate reaches the comparator.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < SAD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SAD_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign out_valid = pipe_q[SAD_LAT-1].valid;
  assign out_x     = pipe_q[SAD_LAT-1].x;
  assign out_y     = pipe_q[SAD_LAT-1].y;

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search motion-estimation sequencer: clears the SAD comparator, walks every
// candidate displacement in raster order, waits for the SAD pipeline to drain and
// hands the winning motion vector downstream over a valid/ready handshake.
module me_search_ctrl
  import me_pkg::*;
#(
  parameter int SEARCH_W = 32,
  parameter int SEARCH_H = 32,
  parameter int SAD_LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  input  logic                 mem_ready,
  output logic                 cand_valid,
  output logic [ME_ADDR_W-1:0] cand_x,
  output logic [ME_ADDR_W-1:0] cand_y,
  output logic                 cmp_clear,
  output logic                 cmp_valid,
  output logic [ME_ADDR_W-1:0] cmp_addr,
  output logic [ME_ADDR_W-1:0] cmp_amt,
  input  logic [ME_SAD_W-1:0]  min_sad,
  input  logic [ME_ADDR_W-1:0] mv_x,
  input  logic [ME_ADDR_W-1:0] mv_y,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ME_SAD_W-1:0]  res_sad,
  output logic [ME_ADDR_W-1:0] res_mv_x,
  output logic [ME_ADDR_W-1:0] res_mv_y
);

  localparam logic [ME_ADDR_W-1:0] X_LAST     = ME_ADDR_W'(SEARCH_W - 1);
  localparam logic [ME_ADDR_W-1:0] Y_LAST     = ME_ADDR_W'(SEARCH_H - 1);
  localparam logic [3:0]           DRAIN_LOAD = 4'(SAD_LAT);

  me_state_t             state_q, state_d;
  logic [ME_ADDR_W-1:0]  x_q, x_d;
  logic [ME_ADDR_W-1:0]  y_q, y_d;
  logic [3:0]            drain_q, drain_d;
  logic                  busy_q, busy_d;
  logic                  cmp_clear_q, cmp_clear_d;
  logic                  res_valid_q, res_valid_d;
  logic [ME_SAD_W-1:0]   res_sad_q, res_sad_d;
  logic [ME_ADDR_W-1:0]  res_mv_x_q, res_mv_x_d;
  logic [ME_ADDR_W-1:0]  res_mv_y_q, res_mv_y_d;
  logic                  issue;

  // A candidate goes out whenever we are scanning and the window memory can take it.
  assign issue = (state_q == SCAN) && mem_ready;

  // Next-state, scan-position, drain-count and result-capture logic for the search sequencer.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    drain_d    = drain_q;
    res_sad_d  = res_sad_q;
    res_mv_x_d = res_mv_x_q;
    res_mv_y_d = res_mv_y_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        x_d     = '0;
        y_d     = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (issue) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              drain_d = DRAIN_LOAD;
              state_d = DRAIN;
            end else begin
              y_d = y_q + 6'd1;
            end
          end else begin
            x_d = x_q + 6'd1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == 4'd0) begin
          res_sad_d = min_sad;
          if (min_sad == ME_SAD_MAX) begin
            res_mv_x_d = '0;
            res_mv_y_d = '0;
          end else begin
            res_mv_x_d = mv_x;
            res_mv_y_d = mv_y;
          end
          state_d = DONE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    cmp_clear_d = (state_d == CLEAR);
    res_valid_d = (state_d == DONE);
  end

  // Single state register for the FSM and all of its registered outputs; reset discards any search.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      cmp_clear_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_sad_q   <= ME_SAD_MAX;
      res_mv_x_q  <= '0;
      res_mv_y_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      cmp_clear_q <= cmp_clear_d;
      res_valid_q <= res_valid_d;
      res_sad_q   <= res_sad_d;
      res_mv_x_q  <= res_mv_x_d;
      res_mv_y_q  <= res_mv_y_d;
    end
  end

  me_cand_delay #(
    .SAD_LAT (SAD_LAT)
  ) u_cand_delay (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (issue),
    .in_x      (x_q),
    .in_y      (y_q),
    .out_valid (cmp_valid),
    .out_x     (cmp_addr),
    .out_y     (cmp_amt)
  );

  assign busy       = busy_q;
  assign cand_valid = issue;
  assign cand_x     = x_q;
  assign cand_y     = y_q;
  assign cmp_clear  = cmp_clear_q;
  assign res_valid  = res_valid_q;
  assign res_sad    = res_sad_q;
  assign res_mv_x   = res_mv_x_q;
  assign res_mv_y   = res_mv_y_q;

endmodule
